mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Parametrised, multi-cycle RISC-V M-extension unit.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, plus the RV64 W-variants when XLEN=64.
- Uses a radix-2 shift-add multiplier and a restoring divider, one bit per cycle.
- Sits in the EXU beside the ALU with valid/ready handshakes on both sides and a pipeline flush input.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.
- WORD_OPS, 1, enables the `word` input (32-bit op, sign-extended result); forced to 0 when XLEN=32.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- word  in  1  W-variant (MULW/DIVW/DIVUW/REMW/REMUW); ignored if WORD_OPS=0
- src1  in  XLEN  rs1 operand
- src2  in  XLEN  rs2 operand
- flush  in  1  kill any in-flight or completed-but-unconsumed operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  XLEN  result

Behaviour:
- Reset (async, reset_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, all internal registers 0.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: in_ready = ~flush. On in_valid&in_ready, latch op/word/operands.
    - Word ops first truncate to [31:0], then sign- or zero-extend as the op requires.
    - Go to MUL (op<4) or DIV (op>=4). Load counter N = (word ? 32 : XLEN).
  - MUL: operands are held as magnitudes.
    - Signed ops take the absolute value of signed sources; MULHSU treats src2 as unsigned.
    - Each cycle: add-shift, counter--. At counter==0, apply sign fix to the 2*XLEN product, register the selected slice into result, go to DONE.
  - DIV: restoring division on magnitudes, same counter. At counter==0, sign-correct and register the result, go to DONE.
    - Quotient sign = sign1^sign2.
    - Remainder sign = sign of dividend.
  - DONE: out_valid=1 and result held stable until out_ready. On out_valid&out_ready, go to IDLE; in_ready rises the next cycle (no back-to-back bypass).
- Latency: accept in cycle 0; out_valid is first high in cycle N+1. N=XLEN (64) or 32 for word ops.
- Result selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - Word ops: low 32 bits of the 32-bit result, sign-extended to XLEN. This applies to DIVUW/REMUW too.
- Divide-by-zero:
  - DIV/DIVU quotient = all ones (XLEN bits, or 32 bits then sign-extended for W).
  - REM/REMU = dividend.
- Signed overflow (dividend = most-negative of the effective width, divisor = -1):
  - DIV = dividend.
  - REM = 0.
  - Both are detected explicitly. Iteration still runs unless MDU_EARLY_OUT_EN is defined.
- flush: synchronous and highest priority.
  - From any state, next state is IDLE and out_valid=0 next cycle; the result is discarded.
  - While flush=1, in_ready=0, so a request presented with flush is not accepted.
- in_ready=0 in MUL/DIV/DONE. Input ports are don't-care outside the accept cycle.
- reset_n deasserted mid-operation: immediate return to reset values; no partial result is emitted.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: in IDLE, divide-by-zero, signed overflow, or src2==0 for any multiply bypass iteration.
  - The special result is registered and the FSM goes straight to DONE.
  - out_valid is high in cycle 1 after accept.
- Undefined: every op takes the full N+1 latency; special values are applied at completion.

Decomposition:
- Package mdu_pkg: op encoding localparams (MDU_MUL..MDU_REMU), state encoding (IDLE/MUL/DIV/DONE), and a function for the signed-overflow constant per width.
- One sub-module: mdu_div_step, a combinational single restoring-divide step (partial remainder, divisor → next remainder, quotient bit). It is instantiated once in mdu_iter.

Test Plan:
- MUL, XLEN=64: src1=0xFFFF_FFFF_FFFF_FFFF (-1), src2=3 → result 0xFFFF_FFFF_FFFF_FFFD, out_valid in cycle 65. Same operands with MULHU → 0x0000_0000_0000_0002. With MULH → 0xFFFF_FFFF_FFFF_FFFF.
- DIV by zero: src1=0x1234, src2=0 → 0xFFFF_FFFF_FFFF_FFFF. Same operands with REMU → 0x1234. DIVW by zero → 0xFFFF_FFFF_FFFF_FFFF, out_valid in cycle 33.
- Overflow: DIV with src1=0x8000_0000_0000_0000, src2=-1 → 0x8000_0000_0000_0000, and REM → 0. REMW with src1=0x8000_0000, src2=-1 → 0.
- Word sign-extension: DIVUW with src1=0xFFFF_FFFF, src2=1 → 0xFFFF_FFFF_FFFF_FFFF. MULW with src1=0x7FFF_FFFF, src2=2 → 0xFFFF_FFFF_FFFF_FFFE.
- Handshake:
  - out_ready=0 for 5 cycles after completion → result stable, in_ready=0.
  - Then out_ready=1 → in_ready=1 on the next cycle.
  - Flush at cycle 10 of a DIV → no out_valid, in_ready=1 in cycle 11.
- Reset: pull reset_n low mid-MUL → in_ready=1, out_valid=0, result=0 without a clock edge. With MDU_EARLY_OUT_EN, DIV by zero → out_valid in cycle 1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RISC-V M-extension unit: opcode
// encodings, FSM state encoding and the signed-overflow dividend constant.
package mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    // Most-negative value of the effective width, sign-extended to 64 bits;
    // callers keep the low XLEN bits.
    function automatic logic [63:0] mdu_min_neg(input logic is_word, input int xlen);
        if (is_word || (xlen == 32'sd32)) begin
            mdu_min_neg = 64'hFFFF_FFFF_8000_0000;
        end else begin
            mdu_min_neg = 64'h8000_0000_0000_0000;
        end
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] part_rem,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic            q_bit
);

    logic [XLEN:0] trial_s;

    // Trial subtraction; the difference always fits XLEN bits when it is kept.
    always_comb begin
        trial_s = {part_rem, dvd_bit};
        if (trial_s >= {1'b0, divisor}) begin
            q_bit    = 1'b1;
            next_rem = trial_s[XLEN-1:0] - divisor;
        end else begin
            q_bit    = 1'b0;
            next_rem = trial_s[XLEN-1:0];
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiplier and
// restoring divider, one bit per cycle. Define MDU_EARLY_OUT_EN to finish
// divide-by-zero, signed overflow and multiply-by-zero right after accept.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int WORD_OPS = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam bit                WORD_EN = (XLEN == 32'sd64) && (WORD_OPS != 32'sd0);
    localparam logic [XLEN-1:0]   ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X  = {{(2*XLEN-1){1'b0}}, 1'b1};

    function automatic logic [XLEN-1:0] fix_word(input logic is_word, input logic [XLEN-1:0] v);
        if (is_word) begin
            fix_word = XLEN'(signed'(v[31:0]));
        end else begin
            fix_word = v;
        end
    endfunction

    function automatic logic [XLEN-1:0] div_special(input logic is_rem, input logic dbz,
                                                    input logic [XLEN-1:0] dvd);
        if (is_rem) begin
            div_special = dbz ? dvd : {XLEN{1'b0}};
        end else begin
            div_special = dbz ? {XLEN{1'b1}} : dvd;
        end
    endfunction

    mdu_state_e          state_r, state_nxt_s;
    logic [2:0]          op_r, op_nxt_s;
    logic                word_r, word_nxt_s;
    logic                neg_r, neg_nxt_s;
    logic                rem_neg_r, rem_neg_nxt_s;
    logic                dbz_r, dbz_nxt_s;
    logic                ovf_r, ovf_nxt_s;
    logic [6:0]          cnt_r, cnt_nxt_s;
    logic [XLEN-1:0]     a_r, a_nxt_s;
    logic [XLEN-1:0]     op1_r, op1_nxt_s;
    logic [2*XLEN-1:0]   acc_r, acc_nxt_s;
    logic [XLEN-1:0]     result_r, result_nxt_s;
    logic                out_valid_r, valid_nxt_s;

    logic                is_word_s, is_div_s, s1_sgn_s, s2_sgn_s, neg1_s, neg2_s;
    logic                dbz_s, ovf_s;
    logic [XLEN-1:0]     op1_ext_s, op2_ext_s, mag1_s, mag2_s;
    logic [63:0]         min_neg_s;

    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   mul_nxt_s, div_nxt_s, prod_s;
    logic [XLEN-1:0]     mul_res_s, div_res_s, quot_s, remd_s, div_raw_s, div_rem_s;
    logic                div_q_s;

    // Operand decode: truncation/extension for word ops, signs and magnitudes.
    always_comb begin
        is_word_s = WORD_EN & word;
        is_div_s  = op[2];
        case (op)
            MDU_MULH, MDU_DIV, MDU_REM: begin
                s1_sgn_s = 1'b1;
                s2_sgn_s = 1'b1;
            end
            MDU_MULHSU: begin
                s1_sgn_s = 1'b1;
                s2_sgn_s = 1'b0;
            end
            default: begin
                s1_sgn_s = 1'b0;
                s2_sgn_s = 1'b0;
            end
        endcase
        if (is_word_s) begin
            op1_ext_s = s1_sgn_s ? fix_word(1'b1, src1) : XLEN'(src1[31:0]);
            op2_ext_s = s2_sgn_s ? fix_word(1'b1, src2) : XLEN'(src2[31:0]);
        end else begin
            op1_ext_s = src1;
            op2_ext_s = src2;
        end
        neg1_s    = s1_sgn_s & op1_ext_s[XLEN-1];
        neg2_s    = s2_sgn_s & op2_ext_s[XLEN-1];
        mag1_s    = neg1_s ? (~op1_ext_s + ONE_X) : op1_ext_s;
        mag2_s    = neg2_s ? (~op2_ext_s + ONE_X) : op2_ext_s;
        min_neg_s = mdu_min_neg(is_word_s, XLEN);
        dbz_s     = is_div_s & (op2_ext_s == {XLEN{1'b0}});
        ovf_s     = is_div_s & s1_sgn_s & (op1_ext_s == min_neg_s[XLEN-1:0])
                    & (op2_ext_s == {XLEN{1'b1}});
    end

`ifdef MDU_EARLY_OUT_EN
    logic            early_s;
    logic [XLEN-1:0] early_res_s;

    // Requests whose result is known without iterating.
    always_comb begin
        if (is_div_s) begin
            early_s     = dbz_s | ovf_s;
            early_res_s = fix_word(is_word_s, div_special(op[1], dbz_s, op1_ext_s));
        end else begin
            early_s     = (op2_ext_s == {XLEN{1'b0}});
            early_res_s = {XLEN{1'b0}};
        end
    end
`endif

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .part_rem (acc_r[2*XLEN-1:XLEN]),
        .dvd_bit  (acc_r[XLEN-1]),
        .divisor  (a_r),
        .next_rem (div_rem_s),
        .q_bit    (div_q_s)
    );

    // One iteration of each datapath plus the sign-corrected final results.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, a_r} : {(XLEN+1){1'b0}});
        mul_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
        div_nxt_s = {div_rem_s, acc_r[XLEN-2:0], div_q_s};
        prod_s    = neg_r ? (~mul_nxt_s + ONE_2X) : mul_nxt_s;
        // After 32 iterations the word product sits just above the unused multiplier bits.
        if (op_r == MDU_MUL) begin
            if (word_r) begin
                mul_res_s = fix_word(1'b1, XLEN'(mul_nxt_s[XLEN-1 -: 32]));
            end else begin
                mul_res_s = prod_s[XLEN-1:0];
            end
        end else begin
            mul_res_s = prod_s[2*XLEN-1:XLEN];
        end
        quot_s = neg_r ? (~div_nxt_s[XLEN-1:0] + ONE_X) : div_nxt_s[XLEN-1:0];
        remd_s = rem_neg_r ? (~div_nxt_s[2*XLEN-1:XLEN] + ONE_X) : div_nxt_s[2*XLEN-1:XLEN];
        if (dbz_r | ovf_r) begin
            div_raw_s = div_special(op_r[1], dbz_r, op1_r);
        end else begin
            div_raw_s = op_r[1] ? remd_s : quot_s;
        end
        div_res_s = fix_word(word_r, div_raw_s);
    end

    // Next-state and next-register logic; flush overrides everything.
    always_comb begin
        state_nxt_s   = state_r;
        op_nxt_s      = op_r;
        word_nxt_s    = word_r;
        neg_nxt_s     = neg_r;
        rem_neg_nxt_s = rem_neg_r;
        dbz_nxt_s     = dbz_r;
        ovf_nxt_s     = ovf_r;
        cnt_nxt_s     = cnt_r;
        a_nxt_s       = a_r;
        op1_nxt_s     = op1_r;
        acc_nxt_s     = acc_r;
        result_nxt_s  = result_r;
        valid_nxt_s   = out_valid_r;
        if (flush) begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_nxt_s      = op;
                        word_nxt_s    = is_word_s;
                        neg_nxt_s     = neg1_s ^ neg2_s;
                        rem_neg_nxt_s = neg1_s;
                        dbz_nxt_s     = dbz_s;
                        ovf_nxt_s     = ovf_s;
                        op1_nxt_s     = op1_ext_s;
                        cnt_nxt_s     = is_word_s ? 7'd32 : 7'(XLEN);
                        if (is_div_s) begin
                            a_nxt_s = mag2_s;
                            if (is_word_s) begin
                                acc_nxt_s = {{XLEN{1'b0}}, mag1_s << (XLEN - 32)};
                            end else begin
                                acc_nxt_s = {{XLEN{1'b0}}, mag1_s};
                            end
                        end else begin
                            a_nxt_s   = mag1_s;
                            acc_nxt_s = {{XLEN{1'b0}}, mag2_s};
                        end
`ifdef MDU_EARLY_OUT_EN
                        if (early_s) begin
                            state_nxt_s  = DONE;
                            valid_nxt_s  = 1'b1;
                            result_nxt_s = early_res_s;
                        end else begin
                            state_nxt_s = is_div_s ? DIV : MUL;
                        end
`else
                        state_nxt_s = is_div_s ? DIV : MUL;
`endif
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                MUL: begin
                    acc_nxt_s = mul_nxt_s;
                    cnt_nxt_s = cnt_r - 7'd1;
                    if (cnt_r == 7'd1) begin
                        state_nxt_s  = DONE;
                        valid_nxt_s  = 1'b1;
                        result_nxt_s = mul_res_s;
                    end else begin
                        state_nxt_s = MUL;
                    end
                end
                DIV: begin
                    acc_nxt_s = div_nxt_s;
                    cnt_nxt_s = cnt_r - 7'd1;
                    if (cnt_r == 7'd1) begin
                        state_nxt_s  = DONE;
                        valid_nxt_s  = 1'b1;
                        result_nxt_s = div_res_s;
                    end else begin
                        state_nxt_s = DIV;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nxt_s = IDLE;
                        valid_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            op_r        <= 3'd0;
            word_r      <= 1'b0;
            neg_r       <= 1'b0;
            rem_neg_r   <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            cnt_r       <= 7'd0;
            a_r         <= {XLEN{1'b0}};
            op1_r       <= {XLEN{1'b0}};
            acc_r       <= {(2*XLEN){1'b0}};
            result_r    <= {XLEN{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            op_r        <= op_nxt_s;
            word_r      <= word_nxt_s;
            neg_r       <= neg_nxt_s;
            rem_neg_r   <= rem_neg_nxt_s;
            dbz_r       <= dbz_nxt_s;
            ovf_r       <= ovf_nxt_s;
            cnt_r       <= cnt_nxt_s;
            a_r         <= a_nxt_s;
            op1_r       <= op1_nxt_s;
            acc_r       <= acc_nxt_s;
            result_r    <= result_nxt_s;
            out_valid_r <= valid_nxt_s;
        end
    end

    assign in_ready  = (state_r == IDLE) & ~flush;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule
